// File: rtl/cim_tb_mem_loader_pkg.sv
// Shared types and constants for the CIM memory write loader.
// Width aliases mirror the CIM's CompFx / address types.
package cim_tb_mem_loader_pkg;

  localparam int COMP_FX_W      = 22;
  localparam int PARAM_ADDR_W   = 16;
  localparam int INT_RES_ADDR_W = 16;
  localparam int FX_FMT_W       = 3;

  typedef logic [COMP_FX_W-1:0]      CompFx_t;
  typedef logic [PARAM_ADDR_W-1:0]   ParamAddr_t;
  typedef logic [INT_RES_ADDR_W-1:0] IntResAddr_t;
  typedef logic [FX_FMT_W-1:0]       FxFormat_t;

  localparam FxFormat_t FX_INT   = 3'd0;
  localparam FxFormat_t FX_Q2_20 = 3'd1;
  localparam FxFormat_t FX_Q4_18 = 3'd2;
  localparam FxFormat_t FX_Q8_14 = 3'd3;

  typedef enum logic {
    SINGLE = 1'b0,
    DOUBLE = 1'b1
  } DataWidth_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } loader_state_t;

  localparam int PARAM_CH   = 0;
  localparam int INT_RES_CH = 1;

  // A double-width word occupies two consecutive addresses.
  function automatic int addr_step(input DataWidth_t dw);
    return (dw == DOUBLE) ? 2 : 1;
  endfunction

endpackage

// File: rtl/cim_tb_req_fifo.sv
// Synchronous request FIFO; read data is the head entry, valid while !empty.
// Pointers wrap naturally since DEPTH is a power of two.
module cim_tb_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign count    = count_reg;

endmodule

// File: rtl/cim_tb_mem_loader.sv
// Write-side loader: queues write requests, resolves auto-increment addresses
// at enqueue, and issues one registered memory write per cycle unless the CIM is busy.
module cim_tb_mem_loader
  import cim_tb_mem_loader_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 22,
  parameter int ADDR_W  = 16,
  parameter int FMT_W   = 3,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_ch,
  input  logic              req_inc,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [FMT_W-1:0]  req_format,
  input  logic              req_dbl,
  input  logic              cim_busy,
  output logic [NUM_CH-1:0] mem_en,
  output logic [NUM_CH-1:0] mem_chip_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [FMT_W-1:0]  mem_format,
  output logic              mem_dbl,
  output logic              idle,
  output logic              err_wrap,
  output logic              err_ch
);

  localparam int FAW     = $clog2(DEPTH);
  localparam int ENTRY_W = CH_W + ADDR_W + DATA_W + FMT_W + 2;

  logic [ADDR_W-1:0]  cnt_reg [NUM_CH];
  logic               err_wrap_reg, err_ch_reg;
  logic [NUM_CH-1:0]  ch_hit, pop_onehot;
  logic               ch_valid, accept;
  logic [ADDR_W-1:0]  base_addr, res_addr;
  logic [ADDR_W:0]    addr_sum;

  logic [ENTRY_W-1:0] push_word, pop_word;
  logic               fifo_empty, fifo_full;
  logic [FAW:0]       fifo_count;
  logic [CH_W-1:0]    pop_ch;
  logic [ADDR_W-1:0]  pop_addr;
  logic [DATA_W-1:0]  pop_data;
  logic [FMT_W-1:0]   pop_fmt;
  logic               pop_dbl, pop_valid;

  loader_state_t      state_reg, state_next;
  logic               do_pop, last_entry;
  logic [NUM_CH-1:0]  mem_en_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [DATA_W-1:0]  mem_data_reg;
  logic [FMT_W-1:0]   mem_format_reg;
  logic               mem_dbl_reg;

  assign ch_valid = 32'(req_ch) < 32'(NUM_CH);
  assign accept   = req_valid && req_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_hit[gi]     = ch_valid && (req_ch == CH_W'(gi));
    assign pop_onehot[gi] = pop_valid && (pop_ch == CH_W'(gi));
  end

  always_comb begin
    base_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) base_addr = cnt_reg[i];
    end
  end

  // Carry out of the ADDR_W-bit counter flags a wrap; the wrapped address is still used.
  assign res_addr = req_inc ? base_addr : req_addr;
  assign addr_sum = {1'b0, res_addr} + (ADDR_W+1)'(addr_step(DataWidth_t'(req_dbl)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_reg[i] <= '0;
      err_wrap_reg <= 1'b0;
      err_ch_reg   <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit[i]) cnt_reg[i] <= addr_sum[ADDR_W-1:0];
      end
      if (ch_valid && addr_sum[ADDR_W]) err_wrap_reg <= 1'b1;
      if (!ch_valid)                    err_ch_reg   <= 1'b1;
    end
  end

  assign push_word = {req_ch, res_addr, req_data, req_format, req_dbl, ch_valid};
  assign {pop_ch, pop_addr, pop_data, pop_fmt, pop_dbl, pop_valid} = pop_word;

  cim_tb_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_word),
    .pop       (do_pop),
    .pop_data  (pop_word),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign req_ready  = !fifo_full;
  assign last_entry = (fifo_count == (FAW+1)'(1)) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    do_pop     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (cim_busy) begin
            state_next = ST_HOLD;
          end else begin
            do_pop     = 1'b1;
            state_next = last_entry ? ST_IDLE : ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else if (cim_busy) begin
          state_next = ST_HOLD;
        end else begin
          do_pop     = 1'b1;
          state_next = last_entry ? ST_IDLE : ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else if (!cim_busy) begin
          do_pop     = 1'b1;
          state_next = last_entry ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Entries for a nonexistent channel are popped silently; the bus keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_reg     <= '0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      mem_format_reg <= '0;
      mem_dbl_reg    <= 1'b0;
    end else begin
      mem_en_reg <= do_pop ? pop_onehot : '0;
      if (do_pop && pop_valid) begin
        mem_addr_reg   <= pop_addr;
        mem_data_reg   <= pop_data;
        mem_format_reg <= pop_fmt;
        mem_dbl_reg    <= pop_dbl;
      end
    end
  end

  assign mem_en      = mem_en_reg;
  assign mem_chip_en = mem_en_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_data    = mem_data_reg;
  assign mem_format  = mem_format_reg;
  assign mem_dbl     = mem_dbl_reg;
  assign idle        = fifo_empty && (mem_en_reg == '0);
  assign err_wrap    = err_wrap_reg;
  assign err_ch      = err_ch_reg;

endmodule

// File: tb/tb_cim_tb_mem_loader.sv
// Directed bench for cim_tb_mem_loader: a 2-channel instance for the main
// scenarios and a 3-channel instance for out-of-range channel handling.
module tb_cim_tb_mem_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_inc, req_dbl, cim_busy;
  logic [0:0]  req_ch;
  logic [15:0] req_addr;
  logic [21:0] req_data;
  logic [2:0]  req_format;
  logic [1:0]  mem_en, mem_chip_en;
  logic [15:0] mem_addr;
  logic [21:0] mem_data;
  logic [2:0]  mem_format;
  logic        mem_dbl, idle, err_wrap, err_ch;

  logic        req_valid3, req_ready3;
  logic [1:0]  req_ch3;
  logic [2:0]  mem_en3, mem_chip_en3;
  logic [15:0] mem_addr3;
  logic [21:0] mem_data3;
  logic [2:0]  mem_format3;
  logic        mem_dbl3, idle3, err_wrap3, err_ch3;

  cim_tb_mem_loader #(.NUM_CH(2), .DEPTH(8), .DATA_W(22), .ADDR_W(16), .FMT_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_inc(req_inc), .req_addr(req_addr), .req_data(req_data),
    .req_format(req_format), .req_dbl(req_dbl), .cim_busy(cim_busy),
    .mem_en(mem_en), .mem_chip_en(mem_chip_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_format(mem_format), .mem_dbl(mem_dbl), .idle(idle), .err_wrap(err_wrap), .err_ch(err_ch)
  );

  cim_tb_mem_loader #(.NUM_CH(3), .DEPTH(8), .DATA_W(22), .ADDR_W(16), .FMT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_ch(req_ch3), .req_inc(req_inc), .req_addr(req_addr), .req_data(req_data),
    .req_format(req_format), .req_dbl(req_dbl), .cim_busy(1'b0),
    .mem_en(mem_en3), .mem_chip_en(mem_chip_en3), .mem_addr(mem_addr3), .mem_data(mem_data3),
    .mem_format(mem_format3), .mem_dbl(mem_dbl3), .idle(idle3), .err_wrap(err_wrap3), .err_ch(err_ch3)
  );

  int checks = 0;
  int failures = 0;
  int chip_bad = 0;
  int unsigned cyc = 0;
  int unsigned log_cyc[$];
  logic [1:0]  log_en[$];
  logic [15:0] log_addr[$];
  logic [21:0] log_data[$];
  logic [2:0]  log3_en[$];
  logic [15:0] log3_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_en != 2'b00) begin
      log_cyc.push_back(cyc);
      log_en.push_back(mem_en);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
      $display("  wr cyc=%0d en=%b addr=0x%04h data=0x%06h", cyc, mem_en, mem_addr, mem_data);
    end
    if (mem_en3 != 3'b000) begin
      log3_en.push_back(mem_en3);
      log3_addr.push_back(mem_addr3);
      $display("  wr3 en=%b addr=0x%04h", mem_en3, mem_addr3);
    end
    if (rst_n === 1'b1 && (mem_chip_en !== mem_en || mem_chip_en3 !== mem_en3)) chip_bad++;
  end

  task automatic clear_log();
    log_cyc.delete(); log_en.delete(); log_addr.delete(); log_data.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic ch, input logic inc, input logic [15:0] addr,
                      input logic [21:0] data, input logic dbl);
    logic rdy;
    req_ch = ch; req_inc = inc; req_addr = addr; req_data = data; req_dbl = dbl;
    req_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); rdy = req_ready;
      tick();
      if (rdy) begin
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (idle) begin
        tick();
        return;
      end
    end
    chk("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [1:0] en,
                        input logic [15:0] addr, input logic [21:0] data);
    if (idx >= log_en.size()) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_en"}, 32'(log_en[idx]), 32'(en));
    chk({tag, "_addr"}, 32'(log_addr[idx]), 32'(addr));
    chk({tag, "_data"}, 32'(log_data[idx]), 32'(data));
  endtask

  task automatic chk_b2b(input string tag, input int first, input int last);
    for (int i = first + 1; i <= last; i++) begin
      if (i < log_cyc.size()) chk(tag, log_cyc[i] - log_cyc[i-1], 32'd1);
      else chk({tag, "_present"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cim_busy = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0;
    req_ch = 1'b0; req_ch3 = 2'd0; req_inc = 1'b0; req_addr = '0; req_data = '0;
    req_format = 3'd5; req_dbl = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_err_wrap", 32'(err_wrap), 32'd0);
    chk("rst_err_ch", 32'(err_ch), 32'd0);
    chk("rst_ready3", 32'(req_ready3), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single write, one-cycle latency
    clear_log();
    send(1'b0, 1'b0, 16'h0010, 22'h12345, 1'b0);
    chk("single_not_yet", 32'(mem_en), 32'd0);
    tick();
    chk("single_en", 32'(mem_en), 32'h1);
    chk("single_addr", 32'(mem_addr), 32'h0010);
    chk("single_data", 32'(mem_data), 32'h12345);
    chk("single_fmt", 32'(mem_format), 32'd5);
    chk("single_busy_idle", 32'(idle), 32'd0);
    tick();
    chk("single_en_drop", 32'(mem_en), 32'd0);
    chk("single_idle", 32'(idle), 32'd1);

    // Auto-increment on channel 1, double width
    clear_log();
    send(1'b1, 1'b0, 16'h0100, 22'h02000, 1'b1);
    send(1'b1, 1'b1, 16'hDEAD, 22'h02001, 1'b1);
    send(1'b1, 1'b1, 16'hBEEF, 22'h02002, 1'b1);
    send(1'b1, 1'b1, 16'h0000, 22'h02003, 1'b1);
    wait_idle();
    chk("inc_count", 32'(log_en.size()), 32'd4);
    chk_wr("inc0", 0, 2'b10, 16'h0100, 22'h02000);
    chk_wr("inc1", 1, 2'b10, 16'h0102, 22'h02001);
    chk_wr("inc2", 2, 2'b10, 16'h0104, 22'h02002);
    chk_wr("inc3", 3, 2'b10, 16'h0106, 22'h02003);
    chk_b2b("inc_b2b", 0, 3);

    // Backpressure: fill the FIFO while busy, then release
    clear_log();
    cim_busy = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 16'(16'h0030 + i), 22'(22'h03000 + i), 1'b0);
    chk("bp_ready_full", 32'(req_ready), 32'd0);
    chk("bp_none_issued", 32'(log_en.size()), 32'd0);
    cim_busy = 1'b0;
    send(1'b0, 1'b0, 16'h0038, 22'h03008, 1'b0);
    wait_idle();
    chk("bp_count", 32'(log_en.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk_wr("bp", i, 2'b01, 16'(16'h0030 + i), 22'(22'h03000 + i));
    chk_b2b("bp_b2b", 0, 8);

    // Hold mid-stream: two writes, then busy, then the remaining three
    clear_log();
    cim_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 16'(16'h0040 + i), 22'(22'h04000 + i), 1'b0);
    cim_busy = 1'b0;
    tick(); tick();
    cim_busy = 1'b1;
    repeat (5) tick();
    chk("hold_partial", 32'(log_en.size()), 32'd2);
    cim_busy = 1'b0;
    wait_idle();
    chk("hold_count", 32'(log_en.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_wr("hold", i, 2'b10, 16'(16'h0040 + i), 22'(22'h04000 + i));
    chk_b2b("hold_b2b", 2, 4);

    // Address wrap on channel 0
    clear_log();
    chk("pre_wrap_err", 32'(err_wrap), 32'd0);
    send(1'b0, 1'b0, 16'hFFFF, 22'h05000, 1'b0);
    send(1'b0, 1'b1, 16'h1234, 22'h05001, 1'b0);
    wait_idle();
    chk_wr("wrap0", 0, 2'b01, 16'hFFFF, 22'h05000);
    chk_wr("wrap1", 1, 2'b01, 16'h0000, 22'h05001);
    chk("wrap_err", 32'(err_wrap), 32'd1);
    chk("main_err_ch", 32'(err_ch), 32'd0);

    // Out-of-range channel on the 3-channel instance, then a valid channel 2 write
    chk("pre_err_ch3", 32'(err_ch3), 32'd0);
    req_inc = 1'b0; req_addr = 16'h0020; req_data = 22'h07000; req_dbl = 1'b0;
    req_ch3 = 2'd3; req_valid3 = 1'b1;
    tick();
    req_ch3 = 2'd2; req_addr = 16'h0021; req_data = 22'h07001;
    tick();
    req_valid3 = 1'b0;
    repeat (4) tick();
    chk("bad_ch_err", 32'(err_ch3), 32'd1);
    chk("bad_ch_writes", 32'(log3_en.size()), 32'd1);
    if (log3_en.size() > 0) begin
      chk("ch2_en", 32'(log3_en[0]), 32'h4);
      chk("ch2_addr", 32'(log3_addr[0]), 32'h0021);
    end
    chk("bad_ch_idle3", 32'(idle3), 32'd1);

    // Reset mid-burst
    cim_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 16'(16'h0050 + i), 22'(22'h06000 + i), 1'b0);
    cim_busy = 1'b0;
    tick();
    chk("rstm_pre_en", 32'(mem_en), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("rstm_en", 32'(mem_en), 32'd0);
    chk("rstm_idle", 32'(idle), 32'd1);
    chk("rstm_ready", 32'(req_ready), 32'd1);
    chk("rstm_err_wrap", 32'(err_wrap), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    send(1'b1, 1'b1, 16'hAAAA, 22'h06100, 1'b0);
    send(1'b0, 1'b1, 16'h5555, 22'h06101, 1'b0);
    wait_idle();
    chk("rstm_count", 32'(log_en.size()), 32'd2);
    chk_wr("rstm_c1", 0, 2'b10, 16'h0000, 22'h06100);
    chk_wr("rstm_c0", 1, 2'b01, 16'h0000, 22'h06101);

    chk("chip_en_eq_en", 32'(chip_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cim_tb_mem_loader.md
# cim_tb_mem_loader

Parametrised write-side loader between the bench/SoC and the CIM's memory write interfaces. Accepts a stream of write requests over a valid/ready handshake, buffers them in a FIFO and issues exactly one memory write per cycle to one of NUM_CH memory channels (channel 0 = params, channel 1 = intermediate results). Adds per-channel auto-incrementing addresses and back-off while the CIM owns memory. It sits in front of cim_centralized's param_write_tb_i / int_res_write_tb_i ports.

## Interface
- NUM_CH, 2, number of memory channels (≥1)
- DEPTH, 8, request FIFO depth (power of 2, ≥2)
- DATA_W, 22, write data width (CompFx_t)
- ADDR_W, 16, address width (widest of ParamAddr_t / IntResAddr_t)
- FMT_W, 3, fixed-point format code width
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full; transfer on valid&ready
- req_ch  in  CH_W=max(1,$clog2(NUM_CH))  target channel
- req_inc  in  1  1: use channel address counter, ignore req_addr
- req_addr  in  ADDR_W  explicit address; also reloads channel counter
- req_data  in  DATA_W  write data
- req_format  in  FMT_W  fixed-point format
- req_dbl  in  1  data width: 0 single, 1 double
- cim_busy  in  1  CIM owns memory; no writes issued
- mem_en  out  NUM_CH  one-hot write enable
- mem_chip_en  out  NUM_CH  chip enable, equal to mem_en
- mem_addr, mem_data, mem_format, mem_dbl  out  ADDR_W/DATA_W/FMT_W/1  shared write bus
- idle  out  1  FIFO empty and no write in flight
- err_wrap  out  1  sticky: auto-increment counter wrapped
- err_ch  out  1  sticky: req_ch ≥ NUM_CH accepted

## Operation
- Reset: FIFO empty, all counters 0, mem_en=0, mem_chip_en=0, mem_addr/data/format/dbl=0, req_ready=1, idle=1, err_* =0, FSM=IDLE.
- Accept: on valid&ready, address is resolved at enqueue: req_inc=0 → addr=req_addr, counter[ch]←req_addr+step; req_inc=1 → addr=counter[ch], counter[ch]←counter[ch]+step. step=1 single, 2 double.
- Counter arithmetic modulo 2^ADDR_W; carry-out sets err_wrap; write still proceeds with wrapped address.
- req_ch ≥ NUM_CH: entry accepted, dropped (no mem write), err_ch set.
- FSM: IDLE (FIFO empty) → ISSUE when FIFO non-empty and !cim_busy; → HOLD when non-empty and cim_busy. ISSUE pops one entry per cycle; → HOLD on cim_busy; → IDLE when FIFO empties. HOLD → ISSUE when cim_busy deasserts.
- Issue: registered outputs; mem_en[ch]=1 for exactly one cycle per write, all other bits 0.
- Simultaneous push and pop when full: not permitted (ready=0 when full); push and pop in same cycle otherwise legal, occupancy unchanged.
- Reset mid-operation: FIFO contents and counters discarded, mem_en drops immediately (asynchronous).
- Error flags clear only on reset.

## Timing
- req_ready combinational from FIFO occupancy (= count<DEPTH).
- Latency: request accepted at edge t into empty FIFO with cim_busy=0 → mem_en high during cycle t+1 to t+2 (1-cycle).
- Throughput: 1 write/cycle sustained; back-to-back requests produce back-to-back mem_en.
- cim_busy sampled at the edge; when high at edge t, no mem_en during following cycle; a write already on the bus completes.
- idle=1 iff FIFO empty and mem_en=0.

## Structure
- Shared package: CompFx_t, ParamAddr_t, IntResAddr_t, FxFormat codes, DataWidth_t enum (SINGLE/DOUBLE), loader FSM state enum, channel index constants PARAM_CH=0, INT_RES_CH=1.
- One sub-module: cim_tb_req_fifo (synchronous FIFO, DEPTH × {ch, addr, data, format, dbl, valid_ch}).
- Channel-to-MemoryInterface mapping (en/chip_en/addr/data/format/data_width) done in the instantiating bench wrapper, not here.

## Test plan
- Single write: ch=0, inc=0, addr=0x0010, data=0x12345 → mem_en=2'b01 one cycle later, mem_addr=0x0010, mem_data=0x12345, idle=1 next cycle.
- Auto-increment: ch=1 addr=0x0100 dbl=1, then 3×inc=1 → addresses 0x0100,0x0102,0x0104,0x0106 on consecutive cycles, mem_en=2'b10 each.
- Backpressure: cim_busy=1, push 9 requests → req_ready=0 after 8th; release cim_busy → 8 writes on 8 consecutive cycles, then 9th accepted and issued.
- Hold mid-stream: cim_busy rises after 2 of 5 writes → exactly 2 issued, 3 held, remainder issued in order after release.
- Wrap: ch=0 addr=0xFFFF inc=0 then inc=1 → writes to 0xFFFF then 0x0000, err_wrap=1; bad channel req_ch=3 (NUM_CH=2, CH_W=1 override NUM_CH=3 bench) → no mem_en, err_ch=1.
- Reset mid-burst: rst_n low with 4 queued → mem_en=0 immediately, idle=1, counters 0 after release.
